// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants, opcode encodings and the reservation-station entry record.
package tomasulo_pkg;

  localparam int RS_ENTRIES = 4;
  localparam int RS_TAG_W   = 5;
  localparam int RS_DATA_W  = 32;
  localparam int RS_OP_W    = 4;
  localparam int RS_AGE_W   = $clog2(RS_ENTRIES);

  localparam logic [RS_OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [RS_OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [RS_OP_W-1:0] OP_AND = 4'h2;
  localparam logic [RS_OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [RS_OP_W-1:0] OP_XOR = 4'h4;
  localparam logic [RS_OP_W-1:0] OP_SLL = 4'h5;
  localparam logic [RS_OP_W-1:0] OP_SRL = 4'h6;
  localparam logic [RS_OP_W-1:0] OP_MUL = 4'h7;

  typedef struct packed {
    logic                 busy;
    logic [RS_OP_W-1:0]   op;
    logic [RS_TAG_W-1:0]  dst;
    logic                 rj;
    logic [RS_DATA_W-1:0] vj;
    logic [RS_TAG_W-1:0]  qj;
    logic                 rk;
    logic [RS_DATA_W-1:0] vk;
    logic [RS_TAG_W-1:0]  qk;
    logic [RS_AGE_W-1:0]  age;
  } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Combinational picker: one-hot grant to the ready entry with the highest age.
module rs_oldest_select #(
  parameter int N     = 4,
  parameter int AGE_W = 2
) (
  input  logic [N-1:0]            i_ready,
  input  logic [N-1:0][AGE_W-1:0] i_age,
  output logic [N-1:0]            o_grant,
  output logic                    o_valid
);

  logic [AGE_W-1:0] w_best;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_best  = '0;
    for (int i = 0; i < N; i++) begin
      if (i_ready[i] && (!w_found || i_age[i] > w_best)) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
        w_best     = i_age[i];
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: holds renamed ops until both operands are ready, dispatches oldest first.
// Optional macro RS_CDB_BYPASS_EN enables same-cycle CDB capture on accept.
module reservation_station
  import tomasulo_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES,
  parameter int TAG_W   = RS_TAG_W,
  parameter int DATA_W  = RS_DATA_W,
  parameter int OP_W    = RS_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [TAG_W-1:0]  issue_dst,
  input  logic              issue_rj,
  input  logic              issue_rk,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [OP_W-1:0]   disp_op,
  output logic [DATA_W-1:0] disp_vj,
  output logic [DATA_W-1:0] disp_vk,
  output logic [TAG_W-1:0]  disp_dst
);

  localparam int AGE_W = RS_AGE_W;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(ENTRIES - 1);

  rs_entry_t r_ent [ENTRIES];

  logic [ENTRIES-1:0]            w_busy, w_ready, w_grant, w_alloc;
  logic [ENTRIES-1:0][AGE_W-1:0] w_age, w_age_next;
  logic [AGE_W-1:0]              w_disp_age;
  logic                          w_any_free, w_accept, w_disp_fire, w_sel_valid, w_hit;
  logic                          w_byp_j, w_byp_k;
  rs_entry_t                     w_new;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_busy[i]  = r_ent[i].busy;
      w_ready[i] = r_ent[i].busy & r_ent[i].rj & r_ent[i].rk;
      w_age[i]   = r_ent[i].age;
    end
  end

  always_comb begin
    w_alloc = '0;
    w_hit   = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!w_busy[i] && !w_hit) begin
        w_alloc[i] = 1'b1;
        w_hit      = 1'b1;
      end
    end
  end

  assign w_any_free = ~&w_busy;

`ifdef RS_CDB_BYPASS_EN
  assign w_byp_j     = ~issue_rj & cdb_valid & (issue_qj == cdb_tag);
  assign w_byp_k     = ~issue_rk & cdb_valid & (issue_qk == cdb_tag);
  assign issue_ready = w_any_free;
`else
  // Without the bypass a broadcast during accept would be missed, so stall issue instead.
  assign w_byp_j     = 1'b0;
  assign w_byp_k     = 1'b0;
  assign issue_ready = w_any_free & ~cdb_valid;
`endif

  assign w_accept = issue_valid & issue_ready;

  rs_oldest_select #(.N(ENTRIES), .AGE_W(AGE_W)) u_sel (
    .i_ready (w_ready),
    .i_age   (w_age),
    .o_grant (w_grant),
    .o_valid (w_sel_valid)
  );

  assign disp_valid  = w_sel_valid;
  assign w_disp_fire = w_sel_valid & disp_ready;

  always_comb begin
    disp_op    = '0;
    disp_vj    = '0;
    disp_vk    = '0;
    disp_dst   = '0;
    w_disp_age = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_grant[i]) begin
        disp_op    = disp_op    | r_ent[i].op;
        disp_vj    = disp_vj    | r_ent[i].vj;
        disp_vk    = disp_vk    | r_ent[i].vk;
        disp_dst   = disp_dst   | r_ent[i].dst;
        w_disp_age = w_disp_age | r_ent[i].age;
      end
    end
  end

  // Ages stay a dense rank: entries older than the departing one close the gap, keeping them unique.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_age_next[i] = w_age[i];
      if (w_disp_fire && (w_age[i] > w_disp_age))
        w_age_next[i] = w_age[i] - 1'b1;
      if (w_accept && (w_age_next[i] != AGE_MAX))
        w_age_next[i] = w_age_next[i] + 1'b1;
    end
  end

  always_comb begin
    w_new      = '0;
    w_new.busy = 1'b1;
    w_new.op   = issue_op;
    w_new.dst  = issue_dst;
    w_new.rj   = issue_rj | w_byp_j;
    w_new.vj   = w_byp_j ? cdb_data : issue_vj;
    w_new.qj   = issue_qj;
    w_new.rk   = issue_rk | w_byp_k;
    w_new.vk   = w_byp_k ? cdb_data : issue_vk;
    w_new.qk   = issue_qk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_ent[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ent[i].busy <= 1'b0;
        r_ent[i].age  <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_accept && w_alloc[i]) begin
          r_ent[i] <= w_new;
        end else if (r_ent[i].busy) begin
          if (cdb_valid && !r_ent[i].rj && (r_ent[i].qj == cdb_tag)) begin
            r_ent[i].rj <= 1'b1;
            r_ent[i].vj <= cdb_data;
          end
          if (cdb_valid && !r_ent[i].rk && (r_ent[i].qk == cdb_tag)) begin
            r_ent[i].rk <= 1'b1;
            r_ent[i].vk <= cdb_data;
          end
          if (w_disp_fire && w_grant[i])
            r_ent[i].busy <= 1'b0;
          r_ent[i].age <= w_age_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (default and RS_CDB_BYPASS_EN builds).
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_op;
  logic [4:0]  issue_dst, issue_qj, issue_qk;
  logic        issue_rj, issue_rk;
  logic [31:0] issue_vj, issue_vk;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        disp_valid, disp_ready;
  logic [3:0]  disp_op;
  logic [31:0] disp_vj, disp_vk;
  logic [4:0]  disp_dst;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_dst(issue_dst), .issue_rj(issue_rj), .issue_rk(issue_rk),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_dst(disp_dst)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_op = '0; issue_dst = '0;
    issue_rj = 1'b0; issue_rk = 1'b0; issue_vj = '0; issue_vk = '0;
    issue_qj = '0; issue_qk = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic iss(input logic [3:0] op, input logic [4:0] dst,
                     input logic rj, input logic [31:0] vj, input logic [4:0] qj,
                     input logic rk, input logic [31:0] vk, input logic [4:0] qk);
    issue_valid = 1'b1; issue_op = op; issue_dst = dst;
    issue_rj = rj; issue_vj = vj; issue_qj = qj;
    issue_rk = rk; issue_vk = vk; issue_qk = qk;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_issue_ready got %0b want 1", issue_ready); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL reset_disp_valid got %0b want 0", disp_valid); end
    n_cmp++; if ({disp_op, disp_vj, disp_vk, disp_dst} !== 73'd0) begin n_err++;
      $display("FAIL reset_disp_fields got op=%h vj=%h vk=%h dst=%h want all 0", disp_op, disp_vj, disp_vk, disp_dst); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_dispatch();
    disp_ready = 1'b1;
    iss(4'h1, 5'd3, 1'b1, 32'd10, 5'd0, 1'b1, 32'd20, 5'd0);
    #1;
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL basic_same_cycle_valid got %0b want 0", disp_valid); end
    step(); idle(); #1;
    n_cmp++; if (disp_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %0b want 1", disp_valid); end
    n_cmp++; if (disp_vj !== 32'd10 || disp_vk !== 32'd20) begin n_err++;
      $display("FAIL basic_operands got vj=%0d vk=%0d want 10 20", disp_vj, disp_vk); end
    n_cmp++; if (disp_dst !== 5'd3 || disp_op !== 4'h1) begin n_err++;
      $display("FAIL basic_dst_op got dst=%0d op=%h want 3 1", disp_dst, disp_op); end
    step();
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL basic_drained got %0b want 0", disp_valid); end
  endtask

  task automatic test_wakeup();
    disp_ready = 1'b1;
    iss(4'h2, 5'd5, 1'b0, 32'd0, 5'd7, 1'b1, 32'd2, 5'd0);
    step(); idle();
    cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_data = 32'hABCD;
    #1;
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL wake_same_cycle got %0b want 0", disp_valid); end
    step(); idle(); #1;
    n_cmp++; if (disp_valid !== 1'b1 || disp_vj !== 32'hABCD || disp_dst !== 5'd5) begin n_err++;
      $display("FAIL wake_dispatch got v=%0b vj=%h dst=%0d want 1 abcd 5", disp_valid, disp_vj, disp_dst); end
    step();
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL wake_drained got %0b want 0", disp_valid); end
  endtask

  task automatic test_full_oldest_first();
    disp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iss(4'h3, 5'(16 + k), 1'b0, 32'd0, 5'd9, 1'b1, 32'(k), 5'd0);
      step();
    end
    idle(); #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL full_issue_ready got %0b want 0", issue_ready); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL full_waiting_valid got %0b want 0", disp_valid); end
    disp_ready = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'h99;
    step(); idle(); #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (disp_valid !== 1'b1 || disp_dst !== 5'(16 + k)) begin n_err++;
        $display("FAIL full_order[%0d] got v=%0b dst=%0d want 1 %0d", k, disp_valid, disp_dst, 16 + k); end
      n_cmp++; if (disp_vj !== 32'h99 || disp_vk !== 32'(k)) begin n_err++;
        $display("FAIL full_operands[%0d] got vj=%h vk=%h want 99 %h", k, disp_vj, disp_vk, k); end
      n_cmp++; if (issue_ready !== (k != 0)) begin n_err++;
        $display("FAIL full_ready[%0d] got %0b want %0b", k, issue_ready, (k != 0)); end
      step();
    end
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL full_drained got %0b want 0", disp_valid); end
  endtask

  task automatic test_hold_stall();
    disp_ready = 1'b0;
    iss(4'h4, 5'd20, 1'b1, 32'd1, 5'd0, 1'b1, 32'd2, 5'd0);
    step();
    iss(4'h5, 5'd21, 1'b1, 32'd3, 5'd0, 1'b1, 32'd4, 5'd0);
    step(); idle(); #1;
    n_cmp++; if (disp_valid !== 1'b1 || disp_dst !== 5'd20) begin n_err++;
      $display("FAIL hold_first got v=%0b dst=%0d want 1 20", disp_valid, disp_dst); end
    step(); step();
    n_cmp++; if (disp_dst !== 5'd20 || disp_vj !== 32'd1 || disp_op !== 4'h4) begin n_err++;
      $display("FAIL hold_stable got dst=%0d vj=%0d op=%h want 20 1 4", disp_dst, disp_vj, disp_op); end
    disp_ready = 1'b1;
    step();
    n_cmp++; if (disp_valid !== 1'b1 || disp_dst !== 5'd21 || disp_vj !== 32'd3) begin n_err++;
      $display("FAIL hold_second got v=%0b dst=%0d vj=%0d want 1 21 3", disp_valid, disp_dst, disp_vj); end
    step();
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL hold_drained got %0b want 0", disp_valid); end
  endtask

  // Younger entry lands in a lower index than an older one; selection must follow age.
  task automatic test_age_vs_index();
    disp_ready = 1'b0;
    iss(4'h6, 5'd24, 1'b0, 32'd0, 5'd13, 1'b1, 32'd7, 5'd0);
    step();
    iss(4'h6, 5'd25, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
    step();
    iss(4'h6, 5'd26, 1'b1, 32'd2, 5'd0, 1'b1, 32'd2, 5'd0);
    step(); idle();
    disp_ready = 1'b1;
    step();
    disp_ready = 1'b0;
    iss(4'h6, 5'd27, 1'b1, 32'd3, 5'd0, 1'b1, 32'd3, 5'd0);
    step(); idle(); #1;
    n_cmp++; if (disp_valid !== 1'b1 || disp_dst !== 5'd26) begin n_err++;
      $display("FAIL age_pick got v=%0b dst=%0d want 1 26", disp_valid, disp_dst); end
    cdb_valid = 1'b1; cdb_tag = 5'd13; cdb_data = 32'h1313;
    step(); idle(); #1;
    n_cmp++; if (disp_dst !== 5'd24 || disp_vj !== 32'h1313) begin n_err++;
      $display("FAIL age_switch got dst=%0d vj=%h want 24 1313", disp_dst, disp_vj); end
    disp_ready = 1'b1;
    step();
    n_cmp++; if (disp_dst !== 5'd26) begin n_err++; $display("FAIL age_order1 got dst=%0d want 26", disp_dst); end
    step();
    n_cmp++; if (disp_dst !== 5'd27 || disp_valid !== 1'b1) begin n_err++;
      $display("FAIL age_order2 got v=%0b dst=%0d want 1 27", disp_valid, disp_dst); end
    step();
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL age_drained got %0b want 0", disp_valid); end
  endtask

  task automatic test_bypass();
    disp_ready = 1'b1;
    iss(4'h7, 5'd6, 1'b1, 32'd5, 5'd0, 1'b0, 32'd0, 5'd12);
    cdb_valid = 1'b1; cdb_tag = 5'd12; cdb_data = 32'h1234;
    #1;
`ifdef RS_CDB_BYPASS_EN
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL byp_issue_ready got %0b want 1", issue_ready); end
    step(); idle(); #1;
    n_cmp++; if (disp_valid !== 1'b1 || disp_vk !== 32'h1234 || disp_dst !== 5'd6) begin n_err++;
      $display("FAIL byp_dispatch got v=%0b vk=%h dst=%0d want 1 1234 6", disp_valid, disp_vk, disp_dst); end
    step();
`else
    n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL nobyp_issue_ready got %0b want 0", issue_ready); end
    step(); idle(); #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL nobyp_ready_after got %0b want 1", issue_ready); end
    step();
`endif
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL byp_drained got %0b want 0", disp_valid); end
  endtask

  task automatic test_flush();
    disp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iss(4'h8, 5'(k + 1), 1'b1, 32'(k), 5'd0, 1'b1, 32'(k), 5'd0);
      step();
    end
    iss(4'h8, 5'd31, 1'b1, 32'd9, 5'd0, 1'b1, 32'd9, 5'd0);
    flush = 1'b1;
    step(); idle(); flush = 1'b0; #1;
    n_cmp++; if (disp_valid !== 1'b0 || issue_ready !== 1'b1) begin n_err++;
      $display("FAIL flush_state got v=%0b ready=%0b want 0 1", disp_valid, issue_ready); end
    disp_ready = 1'b1;
    step(); step();
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL flush_not_held got %0b want 0", disp_valid); end
    iss(4'h9, 5'd2, 1'b1, 32'd77, 5'd0, 1'b1, 32'd88, 5'd0);
    step(); idle(); #1;
    n_cmp++; if (disp_valid !== 1'b1 || disp_dst !== 5'd2 || disp_vj !== 32'd77) begin n_err++;
      $display("FAIL flush_reuse got v=%0b dst=%0d vj=%0d want 1 2 77", disp_valid, disp_dst, disp_vj); end
    step();
  endtask

  task automatic test_reset_mid();
    disp_ready = 1'b0;
    iss(4'hA, 5'd11, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
    step();
    iss(4'hA, 5'd12, 1'b1, 32'd2, 5'd0, 1'b1, 32'd2, 5'd0);
    step(); idle();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (disp_valid !== 1'b0 || issue_ready !== 1'b1 || disp_dst !== 5'd0) begin n_err++;
      $display("FAIL rst_mid got v=%0b ready=%0b dst=%0d want 0 1 0", disp_valid, issue_ready, disp_dst); end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_after got %0b want 0", disp_valid); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_ready = 1'b0;
    idle();
    test_reset();
    test_basic_dispatch();
    test_wakeup();
    test_full_oldest_first();
    test_hold_stall();
    test_age_vs_index();
    test_bypass();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
